// File: rtl/top_channel_receiver.sv
// Receiver for the 2-bit serial top channel. Detects a start marker,
// deserialises BEATS data beats LSB-beat-first into a shadow register,
// checks the 2-bit XOR parity beat and publishes the value on top.
//
// Ports:
//   clock       - system clock, rising edge
//   rst         - synchronous active-low reset
//   topChannel  - serial input: 00 idle, 11 start, then data beats, then parity
//   top         - last correctly received value, held until replaced
//   topValid    - set when a frame passes parity, cleared by next start marker
//   newTop      - one-cycle pulse when top is updated
//   receiving   - high from start marker until the parity beat is checked
//   parityError - sticky parity mismatch flag, cleared by next start marker
module top_channel_receiver #(
  parameter int unsigned TOP_BITS = 128
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [1:0]          topChannel,
  output logic [TOP_BITS-1:0] top,
  output logic                topValid,
  output logic                newTop,
  output logic                receiving,
  output logic                parityError
);

  localparam int unsigned BEATS = TOP_BITS / 2;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;

  logic [1:0]          state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [TOP_BITS-1:0] shadow, shadow_n;
  logic [1:0]          par, par_n;
  logic [TOP_BITS-1:0] top_n;
  logic                valid_n, newtop_n, recv_n, perr_n;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shadow      <= '0;
      par         <= '0;
      top         <= '0;
      topValid    <= 1'b0;
      newTop      <= 1'b0;
      receiving   <= 1'b0;
      parityError <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shadow      <= shadow_n;
      par         <= par_n;
      top         <= top_n;
      topValid    <= valid_n;
      newTop      <= newtop_n;
      receiving   <= recv_n;
      parityError <= perr_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shadow_n = shadow;
    par_n    = par;
    top_n    = top;
    valid_n  = topValid;
    newtop_n = 1'b0;
    recv_n   = receiving;
    perr_n   = parityError;

    case (state)
      IDLE: begin
        if (topChannel == 2'b11) begin
          state_n = DATA;
          cnt_n   = '0;
          par_n   = '0;
          recv_n  = 1'b1;
          valid_n = 1'b0;
          perr_n  = 1'b0;
        end
      end
      DATA: begin
        // Shift right so the first beat ends up in the lowest bits
        shadow_n = {topChannel, shadow[TOP_BITS-1:2]};
        par_n    = par ^ topChannel;
        if (cnt == CNT_W'(BEATS - 1)) begin
          state_n = PARITY;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        if (topChannel == par) begin
          top_n    = shadow;
          valid_n  = 1'b1;
          newtop_n = 1'b1;
        end else begin
          perr_n = 1'b1;
        end
        state_n = IDLE;
        recv_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        recv_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_top_channel_receiver.sv
// Directed bench for top_channel_receiver: reset, good/bad parity frames,
// all-ones data, mid-frame reset and back-to-back frames.
module tb_top_channel_receiver;

  localparam int unsigned TOP_BITS = 128;
  localparam int unsigned BEATS    = TOP_BITS / 2;

  logic                clock;
  logic                rst;
  logic [1:0]          topChannel;
  logic [TOP_BITS-1:0] top;
  logic                topValid;
  logic                newTop;
  logic                receiving;
  logic                parityError;

  int checks = 0;
  int errors = 0;

  logic [TOP_BITS-1:0] exp_top;
  logic                exp_valid;
  logic                exp_perr;

  int cyc = 0;
  int pulse_cyc[$];

  localparam logic [TOP_BITS-1:0] VAL_A   = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [TOP_BITS-1:0] VAL_B   = 128'hDEADBEEF_CAFEF00D_13579BDF_02468ACE;
  localparam logic [TOP_BITS-1:0] VAL_ONE = 128'h1;
  localparam logic [TOP_BITS-1:0] VAL_FF  = {TOP_BITS{1'b1}};
  localparam logic [TOP_BITS-1:0] VAL_55  = {(TOP_BITS/2){2'b01}};

  top_channel_receiver #(.TOP_BITS(TOP_BITS)) dut (
    .clock       (clock),
    .rst         (rst),
    .topChannel  (topChannel),
    .top         (top),
    .topValid    (topValid),
    .newTop      (newTop),
    .receiving   (receiving),
    .parityError (parityError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;
  always @(negedge clock) if (newTop) pulse_cyc.push_back(cyc);

  task automatic check(input string tag, input logic [TOP_BITS-1:0] got,
                       input logic [TOP_BITS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Start marker, BEATS data beats, parity beat; outputs checked after parity
  task automatic send_frame(input logic [TOP_BITS-1:0] val, input bit bad);
    logic [1:0] p;
    p = 2'b00;
    topChannel = 2'b11;
    step();
    check("recv_start", receiving, 1'b1);
    check("valid_clr_start", topValid, 1'b0);
    check("perr_clr_start", parityError, 1'b0);
    check("newtop_low_start", newTop, 1'b0);
    for (int k = 0; k < BEATS; k++) begin
      topChannel = val[2*k +: 2];
      p = p ^ val[2*k +: 2];
      step();
      if (k == 30) begin
        check("top_hold_mid", top, exp_top);
        check("recv_mid", receiving, 1'b1);
      end
    end
    topChannel = bad ? ~p : p;
    step();
    if (!bad) begin
      exp_top   = val;
      exp_valid = 1'b1;
      exp_perr  = 1'b0;
    end else begin
      exp_valid = 1'b0;
      exp_perr  = 1'b1;
    end
    check("top_end", top, exp_top);
    check("valid_end", topValid, exp_valid);
    check("newtop_end", newTop, !bad);
    check("perr_end", parityError, exp_perr);
    check("recv_end", receiving, 1'b0);
    topChannel = 2'b00;
  endtask

  initial begin
    int base;
    rst        = 1'b0;
    topChannel = 2'b00;
    exp_top    = '0;
    exp_valid  = 1'b0;
    exp_perr   = 1'b0;

    // Reset for 3 cycles
    repeat (3) step();
    check("rst_top", top, '0);
    check("rst_valid", topValid, 1'b0);
    check("rst_newtop", newTop, 1'b0);
    check("rst_recv", receiving, 1'b0);
    check("rst_perr", parityError, 1'b0);
    rst = 1'b1;

    // Non-start idle codes must not start a frame
    topChannel = 2'b01; step();
    topChannel = 2'b10; step();
    topChannel = 2'b00; step();
    check("idle_no_start", receiving, 1'b0);

    // Bad parity: error set, top stays at reset value
    send_frame(VAL_A, 1'b1);
    step();
    check("perr_sticky", parityError, 1'b1);
    check("bad_top_zero", top, '0);

    // Good frame clears error and loads top; pulse lasts one cycle
    send_frame(VAL_A, 1'b0);
    step();
    check("newtop_one_cycle", newTop, 1'b0);
    check("valid_held", topValid, 1'b1);
    check("top_held", top, VAL_A);

    // All-ones data: 11 beats are data, parity 00
    send_frame(VAL_FF, 1'b0);
    step();
    check("ones_top", top, VAL_FF);

    // Back-to-back frames: pulses 66 cycles apart, valid drops in between
    base = pulse_cyc.size();
    send_frame(VAL_A, 1'b0);
    send_frame(VAL_B, 1'b0);
    step();
    check("b2b_top", top, VAL_B);
    check("b2b_pulses", 32'(pulse_cyc.size() - base), 32'd2);
    if (pulse_cyc.size() - base == 2)
      check("b2b_period", 32'(pulse_cyc[base+1] - pulse_cyc[base]), 32'd66);

    // Reset mid-frame at beat 30 discards the partial frame
    topChannel = 2'b11;
    step();
    for (int k = 0; k <= 30; k++) begin
      topChannel = VAL_55[2*k +: 2];
      step();
    end
    rst        = 1'b0;
    topChannel = 2'b00;
    step();
    exp_top   = '0;
    exp_valid = 1'b0;
    exp_perr  = 1'b0;
    check("midrst_recv", receiving, 1'b0);
    check("midrst_top", top, '0);
    check("midrst_valid", topValid, 1'b0);
    rst = 1'b1;
    step();
    check("midrst_idle", receiving, 1'b0);
    send_frame(VAL_ONE, 1'b0);
    step();
    check("one_top", top, VAL_ONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
